// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, one-outstanding ROM fetch, decode handshake
// Optional IF_MISALIGN_CHK_EN: misaligned redirect targets set a sticky error and halt fetch.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  input  logic        ex_valid,
  input  logic [1:0]  ex_npc_op,
  input  logic        ex_br_true,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_jmp_base,
  input  logic [31:0] ex_imm,
  output logic        misalign_err
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [1:0]  OP_JMP    = 2'b01;
  localparam logic [1:0]  OP_ABSJMP = 2'b10;

  typedef enum logic [2:0] {S_BOOT, S_FETCH, S_WAIT, S_DROP, S_HALT} state_t;
  state_t state, state_nxt;

  logic [31:0] pc, hold_addr, skid_inst, skid_pc;
  logic        skid_valid;
  logic        redir, redir_bad, acc, out_free, ack_take;
  logic [31:0] tgt_raw, tgt;

  always_comb begin
    redir   = ex_valid & (((ex_npc_op == OP_JMP) & ex_br_true) | (ex_npc_op == OP_ABSJMP));
    tgt_raw = (ex_npc_op == OP_ABSJMP) ? ((ex_jmp_base + ex_imm) & 32'hFFFF_FFFE)
                                       : (ex_pc + ex_imm);
  end

`ifdef IF_MISALIGN_CHK_EN
  assign tgt       = tgt_raw;
  assign redir_bad = redir & (tgt_raw[1:0] != 2'b00);
`else
  assign tgt       = tgt_raw & 32'hFFFF_FFFC;
  assign redir_bad = 1'b0;
`endif

  assign acc      = id_valid & id_ready;
  assign out_free = ~id_valid | acc;
  // Data returned for a request issued before a redirect is never consumed.
  assign ack_take = imem_req & imem_ack & (state != S_DROP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    imem_addr = pc;
    case (state)
      S_BOOT: state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = out_free & ~skid_valid;
        if (imem_req & ~imem_ack) state_nxt = redir ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        imem_req = 1'b1;
        if (imem_ack)   state_nxt = S_FETCH;
        else if (redir) state_nxt = S_DROP;
      end
      S_DROP: begin
        // pc already holds the redirect target; keep presenting the stale address.
        imem_req  = 1'b1;
        imem_addr = hold_addr;
        if (imem_ack) state_nxt = S_FETCH;
      end
      default: state_nxt = S_HALT;
    endcase
    if (redir_bad) state_nxt = S_HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      hold_addr  <= RESET_PC;
      id_valid   <= 1'b0;
      id_inst    <= NOP;
      id_pc      <= RESET_PC;
      id_pc4     <= RESET_PC + 32'd4;
      skid_valid <= 1'b0;
      skid_inst  <= NOP;
      skid_pc    <= RESET_PC;
    end else begin
      hold_addr <= imem_addr;
      if (redir) begin
        pc         <= tgt;
        id_valid   <= 1'b0;
        skid_valid <= 1'b0;
      end else begin
        if (ack_take) pc <= pc + 32'd4;
        if (out_free) begin
          if (skid_valid) begin
            id_valid   <= 1'b1;
            id_inst    <= skid_inst;
            id_pc      <= skid_pc;
            id_pc4     <= skid_pc + 32'd4;
            skid_valid <= ack_take;
            if (ack_take) begin
              skid_inst <= imem_rdata;
              skid_pc   <= pc;
            end
          end else if (ack_take) begin
            id_valid <= 1'b1;
            id_inst  <= imem_rdata;
            id_pc    <= pc;
            id_pc4   <= pc + 32'd4;
          end else begin
            id_valid <= 1'b0;
          end
        end else if (ack_take) begin
          skid_valid <= 1'b1;
          skid_inst  <= imem_rdata;
          skid_pc    <= pc;
        end
      end
    end
  end

`ifdef IF_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         misalign_err <= 1'b0;
    else if (redir_bad) misalign_err <= 1'b1;
  end
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized bench for if_fetch_unit with a program-flow reference model
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid, id_ready;
  logic [31:0] id_inst, id_pc, id_pc4;
  logic        ex_valid, ex_br_true;
  logic [1:0]  ex_npc_op;
  logic [31:0] ex_pc, ex_jmp_base, ex_imm;
  logic        misalign_err;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
    .ex_valid(ex_valid), .ex_npc_op(ex_npc_op), .ex_br_true(ex_br_true), .ex_pc(ex_pc),
    .ex_jmp_base(ex_jmp_base), .ex_imm(ex_imm), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // ROM: ack after cur_lat waiting cycles; rom_lat < 0 picks a random latency per request
  int rom_lat  = 0;
  int wait_cnt = 0;
  int cur_lat  = 0;
  assign imem_rdata = rom(imem_addr);
  assign imem_ack   = (wait_cnt >= cur_lat);

  always @(posedge clk) begin
    if (!rst_n || !imem_req || imem_ack) begin
      wait_cnt <= 0;
      cur_lat  <= (rom_lat < 0) ? int'($urandom_range(0, 3)) : rom_lat;
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // Reference model: the accepted stream must follow the program flow exactly
  logic [31:0] exp_pc;
  int          n_acc = 0;
  logic        p_stall = 1'b0, p_redir = 1'b0, p_pend = 1'b0;
  logic [31:0] p_inst, p_pc, p_pc4, p_addr;

  always @(negedge clk) begin
    logic        m_redir;
    logic [31:0] m_tgt;
    if (!rst_n) begin
      exp_pc  = RESET_PC;
      p_stall = 1'b0;
      p_redir = 1'b0;
      p_pend  = 1'b0;
    end else begin
      m_redir = ex_valid && ((ex_npc_op == 2'd1 && ex_br_true) || ex_npc_op == 2'd2);
      m_tgt   = (ex_npc_op == 2'd2) ? ((ex_jmp_base + ex_imm) & ~32'd1) : (ex_pc + ex_imm);
`ifndef IF_MISALIGN_CHK_EN
      m_tgt[1:0] = 2'b00;
`endif
      if (p_pend && !misalign_err) begin
        check("req_held", 32'(imem_req), 32'd1);
        check("addr_held", imem_addr, p_addr);
      end
      if (p_stall && !p_redir) begin
        check("stall_valid", 32'(id_valid), 32'd1);
        check("stall_inst", id_inst, p_inst);
        check("stall_pc", id_pc, p_pc);
        check("stall_pc4", id_pc4, p_pc4);
      end
      if (p_redir) check("redir_flush", 32'(id_valid), 32'd0);
      if (imem_req) check("addr_align", 32'(imem_addr[1:0]), 32'd0);
      if (id_valid && id_ready) begin
        check("acc_pc", id_pc, exp_pc);
        check("acc_inst", id_inst, rom(id_pc));
        check("acc_pc4", id_pc4, id_pc + 32'd4);
        exp_pc = id_pc + 32'd4;
        n_acc++;
      end
      if (m_redir) exp_pc = m_tgt;
      p_pend  = imem_req && !imem_ack;
      p_addr  = imem_addr;
      p_stall = id_valid && !id_ready;
      p_inst  = id_inst;
      p_pc    = id_pc;
      p_pc4   = id_pc4;
      p_redir = m_redir;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_npc_op = 2'd0; ex_br_true = 1'b0;
    ex_pc = 32'd0; ex_jmp_base = 32'd0; ex_imm = 32'd0;
  endtask

  task automatic do_reset(input int lat);
    rst_n = 1'b0;
    #1;
    check("rst_req_drop", 32'(imem_req), 32'd0);
    clear_ex();
    id_ready = 1'b1;
    rom_lat  = lat;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (id_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_redir(input logic [1:0] op, input logic br, input logic [31:0] pcv,
                           input logic [31:0] base, input logic [31:0] imm);
    ex_valid = 1'b1; ex_npc_op = op; ex_br_true = br;
    ex_pc = pcv; ex_jmp_base = base; ex_imm = imm;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit ok;
    int acks;
    int acc0;
    clear_ex();
    id_ready = 1'b1;

    // reset values
    @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_inst", id_inst, 32'h0000_0013);
    check("rst_id_pc", id_pc, RESET_PC);
    check("rst_id_pc4", id_pc4, RESET_PC + 32'd4);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    tick();

    // zero-wait ROM: one instruction per cycle starting at RESET_PC
    do_reset(0);
    @(negedge clk);
    check("boot_req", 32'(imem_req), 32'd0);
    tick();
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RESET_PC);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      check("seq_valid", 32'(id_valid), 32'd1);
      check("seq_pc", id_pc, 32'(4 * k));
      check("seq_pc4", id_pc4, 32'(4 * k + 4));
    end
    tick();

    // three wait states: address held, one instruction every four cycles
    do_reset(3);
    @(negedge clk);
    tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("slow_req", 32'(imem_req), 32'd1);
      check("slow_addr", imem_addr, 32'd0);
      tick();
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("slow_valid", 32'(id_valid), (k % 4 == 0) ? 32'd1 : 32'd0);
      if (k % 4 == 0) check("slow_pc", id_pc, 32'(k));
      tick();
    end

    // decode stall: at most one ack absorbed, then fetch idles
    do_reset(1);
    repeat (6) tick();
    id_ready = 1'b0;
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (imem_req && imem_ack) acks++;
      if (k == 4) begin
        check("stall_idle_req", 32'(imem_req), 32'd0);
        check("stall_hold_valid", 32'(id_valid), 32'd1);
      end
      tick();
    end
    check("stall_acks_le1", (acks <= 1) ? 32'd1 : 32'd0, 32'd1);
    id_ready = 1'b1;
    repeat (10) tick();

    // taken JMP while a request is outstanding: stale data dropped
    do_reset(3);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = (imem_req && wait_cnt == 1);
    end
    check("drop_setup", 32'(ok), 32'd1);
    set_redir(2'd1, 1'b1, 32'h20, 32'h0, 32'hFFFF_FFF8);
    tick();
    clear_ex();
    @(negedge clk);
    check("drop_flush", 32'(id_valid), 32'd0);
    check("drop_req", 32'(imem_req), 32'd1);
    check("drop_addr", imem_addr, 32'd0);
    tick();
    wait_valid(30, ok);
    check("jmp_target_pc", id_pc, 32'h18);
    tick();

    // ABSJMP with bit-0 clear, not-taken JMP, and address wrap
    do_reset(0);
    repeat (4) tick();
    set_redir(2'd2, 1'b0, 32'h0, 32'h101, 32'h4);
    tick();
    clear_ex();
    wait_valid(10, ok);
    check("absjmp_pc", id_pc, 32'h104);
    tick();
    set_redir(2'd1, 1'b0, 32'h40, 32'h0, 32'h100);
    @(negedge clk);
    check("nt_pc0", id_pc, 32'h108);
    tick();
    clear_ex();
    @(negedge clk);
    check("nt_pc1", id_pc, 32'h10C);
    tick();
    set_redir(2'd2, 1'b0, 32'h0, 32'hFFFF_FFF8, 32'h4);
    tick();
    clear_ex();
    wait_valid(10, ok);
    check("wrap_pc", id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", id_pc4, 32'h0);
    tick();
    @(negedge clk);
    check("wrap_next_pc", id_pc, 32'h0);
    tick();

    // misaligned target 0x22
    do_reset(0);
    repeat (4) tick();
    set_redir(2'd1, 1'b1, 32'h20, 32'h0, 32'h2);
    tick();
    clear_ex();
`ifdef IF_MISALIGN_CHK_EN
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mis_err", 32'(misalign_err), 32'd1);
      check("mis_halt_req", 32'(imem_req), 32'd0);
      check("mis_halt_valid", 32'(id_valid), 32'd0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("mis_err_clear", 32'(misalign_err), 32'd0);
    tick();
`else
    wait_valid(10, ok);
    check("mis_forced_pc", id_pc, 32'h20);
    check("mis_err_zero", 32'(misalign_err), 32'd0);
    tick();
`endif

    // randomized traffic against the reference model
    do_reset(-1);
    acc0 = n_acc;
    for (int c = 0; c < 3000; c++) begin
      id_ready    = ($urandom_range(0, 9) < 7);
      ex_valid    = ($urandom_range(0, 15) == 0);
      ex_npc_op   = 2'($urandom_range(0, 3));
      ex_br_true  = 1'($urandom_range(0, 1));
      ex_pc       = 32'($urandom_range(0, 255)) << 2;
      ex_jmp_base = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 1));
      ex_imm      = (32'($urandom_range(0, 63)) - 32'd32) << 2;
      tick();
    end
    clear_ex();
    id_ready = 1'b1;
    repeat (8) tick();
    check("random_progress", ((n_acc - acc0) >= 300) ? 32'd1 : 32'd0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
